sdram_burst_arbiter: RTL
========================

# sdram_burst_arbiter

Schedules the single SDRAM command engine between the camera write path, the LCD read path and the auto-refresh timer. Each grant issues one fixed-length burst (or one refresh) with its start address, then advances per-path address counters that wrap at a frame boundary and report frame completion. It sits between the two clock-domain FIFOs' level flags and the SDRAM command/timing engine, all in the SDRAM controller clock domain.

## Interface
- `ADDR_W`, 22: word address width, as {bank[1:0], offset[19:0]}.
- `BURST`, 256: words per read/write burst; address increment per grant.
- `clk`  in  1  SDRAM controller clock.
- `rst`  in  1  synchronous, active-high reset.
- `init_done`  in  1  SDRAM power-up sequence complete; no grants before it is high.
- `wr_req`  in  1  write FIFO holds ≥ BURST words (level).
- `rd_req`  in  1  read FIFO has room for ≥ BURST words (level).
- `ref_req`  in  1  refresh due (level, held until `cmd_ack` of a refresh).
- `wr_base`, `wr_max`  in  ADDR_W  write frame start / end address (end exclusive).
- `rd_base`, `rd_max`  in  ADDR_W  read frame start / end address.
- `wr_load`, `rd_load`  in  1  one-cycle pulse: reload address counter from base.
- `cmd_valid`  out  1  command presented to engine.
- `cmd_type`  out  2  0 none, 1 write, 2 read, 3 refresh.
- `cmd_addr`  out  ADDR_W  burst start address (0 for refresh).
- `cmd_ack`  in  1  engine accepted command.
- `cmd_done`  in  1  one-cycle pulse: accepted command fully finished.
- `frame_write_done`, `frame_read_done`  out  1  one-cycle pulse at frame wrap.

## Operation
- States: INIT, IDLE, CMD, BUSY. Reset → INIT.
- INIT → IDLE when `init_done`=1.
- IDLE: priority refresh > data. Between data: if only one of wr_req/rd_req high, pick it; if both, pick the one not granted last (`last_rd` flag, reset 0 → write wins first tie). Selection registers cmd_type/cmd_addr; → CMD. No request: stay.
- CMD: `cmd_valid`=1, type/addr stable until `cmd_ack`; on ack → BUSY, `cmd_valid`=0 same edge. Requests dropping in CMD do not withdraw the command.
- BUSY: wait `cmd_done`; on it update counter of granted path, set `last_rd` (data grants only), → IDLE.
- Address update at write done: next = wr_addr + BURST; if next ≥ wr_max then wr_addr ← wr_base and `frame_write_done` pulses; else wr_addr ← next. Read identical with rd_* signals.
- Arithmetic unsigned ADDR_W bits; overflow of addition is treated as ≥ max (compute with one extra bit).
- `wr_load` while no write outstanding: wr_addr ← wr_base next edge. While a write is in CMD/BUSY: latch pending; at that write's `cmd_done` reload from base instead of incrementing, no frame_done pulse. Same for `rd_load`.
- Load and frame wrap on same path same cycle: load wins, no pulse.
- `cmd_done` outside BUSY ignored. `init_done` falling after INIT ignored.
- Reset mid-burst: all state cleared; engine is reset by the same `rst`.

## Timing
- Reset values: cmd_valid 0, cmd_type 0, cmd_addr 0, frame_*_done 0, wr_addr/rd_addr 0 (loaded from base on first load pulse), last_rd 0, pendings 0, state INIT.
- Request sampled in IDLE at edge N → cmd_valid high from N+1.
- cmd_ack sampled same cycle as cmd_valid counts; min command cycle is IDLE→CMD→BUSY→IDLE = 3 cycles + engine latency.
- frame_*_done asserted the cycle after `cmd_done`, exactly one cycle.
- Address counter updated visible at cycle after `cmd_done`; next grant of that path uses updated address.
- Refresh raised while BUSY waits for completion; it is granted at the next IDLE regardless of data requests.

## Test plan
- Reset then init_done=1, wr_req=1 only, wr_base=0, wr_max=1024, wr_load pulse: four write commands at addr 0,256,512,768; frame_write_done pulses once after 4th done; 5th command addr 0.
- wr_req=rd_req=1 continuously: grants alternate W,R,W,R starting with write; rd addresses advance 256 per read grant.
- ref_req asserted during a write's BUSY with both data requests high: next command after cmd_done is type 3, addr 0; ref_req dropped on ack; data alternation resumes.
- rd_load pulse while read in BUSY (rd_addr=512, rd_base=0x100000): at cmd_done rd_addr=0x100000, no frame_read_done.
- cmd_ack delayed 5 cycles: cmd_valid/type/addr held constant 5 cycles; dropping wr_req meanwhile does not change command.
- rst asserted in BUSY: next cycle all outputs at reset values, state INIT; no grant until init_done re-sampled.

Source files
------------

// File: rtl/sdram_burst_arbiter_if.sv
// sdram_burst_arbiter_if
// Command channel between the burst arbiter and the SDRAM command/timing engine.
//
// Handshake: cmd_valid/cmd_type/cmd_addr are held stable from the first cycle
// cmd_valid is high until the cycle in which cmd_ack is sampled high. That cycle
// completes the transfer and cmd_valid drops on the same edge. cmd_done is a
// single-cycle pulse from the engine once the accepted command has finished.
//
// Signals:
//   cmd_valid  arbiter -> engine  command presented
//   cmd_type   arbiter -> engine  0 none, 1 write, 2 read, 3 refresh
//   cmd_addr   arbiter -> engine  burst start word address (0 for refresh)
//   cmd_ack    engine -> arbiter  command accepted
//   cmd_done   engine -> arbiter  accepted command fully finished (pulse)
interface sdram_burst_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              cmd_valid;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ack;
  logic              cmd_done;

  modport master (
    output cmd_valid,
    output cmd_type,
    output cmd_addr,
    input  cmd_ack,
    input  cmd_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_type,
    input  cmd_addr,
    output cmd_ack,
    output cmd_done
  );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter
// Shares the single SDRAM command engine between the camera write path, the
// LCD read path and the auto-refresh timer. Each grant issues one fixed-length
// burst (or one refresh). Per-path address counters advance by BURST on
// completion and wrap to their base at the frame end, pulsing frame_*_done.
//
// Ports:
//   clk, rst            controller clock, synchronous active-high reset
//   init_done           SDRAM power-up complete; gates the first grant
//   wr_req, rd_req      FIFO level flags requesting a data burst
//   ref_req             refresh due, held until its command is acked
//   wr_base, wr_max     write frame start / exclusive end address
//   rd_base, rd_max     read frame start / exclusive end address
//   wr_load, rd_load    pulse: reload the path's address counter from base
//   cmd                 command channel to the engine (master side)
//   frame_write_done    one-cycle pulse when the write counter wraps
//   frame_read_done     one-cycle pulse when the read counter wraps
//   dbg_state           current FSM state (0 INIT, 1 IDLE, 2 CMD, 3 BUSY)
module sdram_burst_arbiter #(
  parameter int ADDR_W = 22,
  parameter int BURST  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_done,
  input  logic                   wr_req,
  input  logic                   rd_req,
  input  logic                   ref_req,
  input  logic [ADDR_W-1:0]      wr_base,
  input  logic [ADDR_W-1:0]      wr_max,
  input  logic [ADDR_W-1:0]      rd_base,
  input  logic [ADDR_W-1:0]      rd_max,
  input  logic                   wr_load,
  input  logic                   rd_load,
  sdram_burst_arbiter_if.master  cmd,
  output logic                   frame_write_done,
  output logic                   frame_read_done,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_CMD  = 2'd2,
    ST_BUSY = 2'd3
  } state_t;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_WR   = 2'd1;
  localparam logic [1:0] T_RD   = 2'd2;
  localparam logic [1:0] T_REF  = 2'd3;

  localparam logic [ADDR_W:0] BURST_X = (ADDR_W+1)'(BURST);

  state_t            state;
  logic              cmd_valid_q;
  logic [1:0]        cmd_type_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              last_rd;
  logic              data_granted;
  logic              wr_pend;
  logic              rd_pend;

  logic              wr_outstanding;
  logic              rd_outstanding;
  logic [ADDR_W:0]   wr_next;
  logic [ADDR_W:0]   rd_next;
  logic              wr_wrap;
  logic              rd_wrap;
  logic              wr_turn;

  assign cmd.cmd_valid = cmd_valid_q;
  assign cmd.cmd_type  = cmd_type_q;
  assign cmd.cmd_addr  = cmd_addr_q;
  assign dbg_state     = state;

  // A path's command is outstanding from selection until its cmd_done.
  assign wr_outstanding = ((state == ST_CMD) || (state == ST_BUSY)) && (cmd_type_q == T_WR);
  assign rd_outstanding = ((state == ST_CMD) || (state == ST_BUSY)) && (cmd_type_q == T_RD);

  // One extra bit so a carry out of the address space counts as past the end.
  assign wr_next = {1'b0, wr_addr} + BURST_X;
  assign rd_next = {1'b0, rd_addr} + BURST_X;
  assign wr_wrap = (wr_next >= {1'b0, wr_max});
  assign rd_wrap = (rd_next >= {1'b0, rd_max});

  // On a tie the write path goes first after reset (no data grant yet),
  // afterwards the path that was not granted last wins.
  assign wr_turn = last_rd | ~data_granted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_INIT;
      cmd_valid_q      <= 1'b0;
      cmd_type_q       <= T_NONE;
      cmd_addr_q       <= '0;
      wr_addr          <= '0;
      rd_addr          <= '0;
      last_rd          <= 1'b0;
      data_granted     <= 1'b0;
      wr_pend          <= 1'b0;
      rd_pend          <= 1'b0;
      frame_write_done <= 1'b0;
      frame_read_done  <= 1'b0;
    end else begin
      frame_write_done <= 1'b0;
      frame_read_done  <= 1'b0;

      // Loads apply at once when the path is quiet, otherwise they are
      // deferred to the completion of the outstanding burst.
      if (wr_load) begin
        if (wr_outstanding) wr_pend <= 1'b1;
        else                wr_addr <= wr_base;
      end
      if (rd_load) begin
        if (rd_outstanding) rd_pend <= 1'b1;
        else                rd_addr <= rd_base;
      end

      case (state)
        ST_INIT: begin
          if (init_done) state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (ref_req) begin
            cmd_type_q  <= T_REF;
            cmd_addr_q  <= '0;
            cmd_valid_q <= 1'b1;
            state       <= ST_CMD;
          end else if (wr_req && (!rd_req || wr_turn)) begin
            cmd_type_q  <= T_WR;
            cmd_addr_q  <= wr_addr;
            cmd_valid_q <= 1'b1;
            state       <= ST_CMD;
          end else if (rd_req) begin
            cmd_type_q  <= T_RD;
            cmd_addr_q  <= rd_addr;
            cmd_valid_q <= 1'b1;
            state       <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (cmd.cmd_ack) begin
            cmd_valid_q <= 1'b0;
            state       <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (cmd.cmd_done) begin
            state      <= ST_IDLE;
            cmd_type_q <= T_NONE;
            cmd_addr_q <= '0;
            case (cmd_type_q)
              T_WR: begin
                data_granted <= 1'b1;
                last_rd      <= 1'b0;
                wr_pend      <= 1'b0;
                // A pending or simultaneous load overrides the frame wrap.
                if (wr_pend || wr_load) begin
                  wr_addr <= wr_base;
                end else if (wr_wrap) begin
                  wr_addr          <= wr_base;
                  frame_write_done <= 1'b1;
                end else begin
                  wr_addr <= wr_next[ADDR_W-1:0];
                end
              end
              T_RD: begin
                data_granted <= 1'b1;
                last_rd      <= 1'b1;
                rd_pend      <= 1'b0;
                if (rd_pend || rd_load) begin
                  rd_addr <= rd_base;
                end else if (rd_wrap) begin
                  rd_addr         <= rd_base;
                  frame_read_done <= 1'b1;
                end else begin
                  rd_addr <= rd_next[ADDR_W-1:0];
                end
              end
              default: ;
            endcase
          end
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
